// File: rtl/serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: nibble width, FSM states,
// and the nibble-counter width helper.
package serial_adder_pkg;

  localparam int unsigned NIB_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Counter must be at least one bit wide even when there is a single nibble.
  function automatic int unsigned cnt_width(input int unsigned nib);
    return (nib <= 2) ? 1 : $clog2(nib);
  endfunction

endpackage

// File: rtl/full_adder_4bit.sv
// 4-bit adder with carry-in/carry-out; the per-cycle datapath of the serial adder.
module full_adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  assign {cout, sum} = 5'(a) + 5'(b) + 5'(cin);

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder processing one nibble per clock via full_adder_4bit.
// Define NSA_OVERFLOW_EN to add the held signed-overflow output ovf.
module nibble_serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef NSA_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned NIB = WIDTH / NIB_W;
  localparam int unsigned CW  = cnt_width(NIB);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [NIB_W-1:0] fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] acc_next;
  logic             last;
`ifdef NSA_OVERFLOW_EN
  logic             ovf_q, ovf_d;
`endif

  full_adder_4bit u_fa (
    .a    (a_sh_q[NIB_W-1:0]),
    .b    (b_sh_q[NIB_W-1:0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // New nibble enters at the top so the accumulator is fully aligned after NIB shifts.
  assign acc_next = (acc_q >> NIB_W) | (WIDTH'(fa_sum) << (WIDTH - NIB_W));
  assign last     = (cnt_q == CW'(NIB - 1));

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
`ifdef NSA_OVERFLOW_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        a_sh_d  = a_sh_q >> NIB_W;
        b_sh_d  = b_sh_q >> NIB_W;
        acc_d   = acc_next;
        carry_d = fa_cout;
        cnt_d   = cnt_q + 1'b1;
        if (last) begin
          sum_d   = acc_next;
          cout_d  = fa_cout;
`ifdef NSA_OVERFLOW_EN
          ovf_d   = (a_sh_q[NIB_W-1] == b_sh_q[NIB_W-1]) &&
                    (fa_sum[NIB_W-1] != a_sh_q[NIB_W-1]);
`endif
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef NSA_OVERFLOW_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
`ifdef NSA_OVERFLOW_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign ready = (state_q != S_RUN);
  assign busy  = (state_q == S_RUN);
  assign done  = (state_q == S_DONE);
  assign sum   = sum_q;
  assign cout  = cout_q;
`ifdef NSA_OVERFLOW_EN
  assign ovf   = ovf_q;
`endif

endmodule
